// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes decoded by the control unit and the loader FSM encoding.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loadState_t;

    function automatic logic isSupportedOp(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_ORI, OP_LUI,
            OP_ANDI, OP_BEQ, OP_LW, OP_SW: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs a big-endian byte stream into 32-bit words; the first byte of each word becomes the MSB.
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byteXfer,
    input  logic [7:0]  byteIn,
    output logic        wordValid,
    output logic [31:0] word
);

    logic [1:0]  byteCnt;
    logic [23:0] shiftReg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byteCnt  <= 2'd0;
            shiftReg <= 24'd0;
        end else if (byteXfer) begin
            byteCnt  <= byteCnt + 2'd1;
            shiftReg <= {shiftReg[15:0], byteIn};
        end
    end

    // The fourth byte is spliced in combinationally so the word is usable in its transfer cycle.
    assign wordValid = byteXfer && (byteCnt == 2'd3) && !clear;
    assign word      = {shiftReg, byteIn};

endmodule

// File: rtl/instr_loader.sv
// Streams a program into instruction memory word by word, flags unsupported opcodes and holds the core until done.
module instr_loader
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic [7:0]            byte_data,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  bad_op,
    output logic [ADDR_WIDTH:0]   bad_count,
    output logic                  cpu_hold,
    output loadState_t            dbgState
);

    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    loadState_t            state;
    logic [ADDR_WIDTH:0]   wordCnt;
    logic [ADDR_WIDTH:0]   numLatched;
    logic                  byteXfer;
    logic                  wordValid;
    logic [31:0]           word;

    // A byte moves only when both sides agree in the same cycle: byte_valid && byte_ready.
    assign byteXfer = byte_valid && byte_ready;
    assign dbgState = state;

    word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == ST_IDLE),
        .byteXfer  (byteXfer),
        .byteIn    (byte_data),
        .wordValid (wordValid),
        .word      (word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bad_op     <= 1'b0;
            bad_count  <= '0;
            cpu_hold   <= 1'b1;
            wordCnt    <= '0;
            numLatched <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        numLatched <= (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
                        wordCnt    <= '0;
                        bad_op     <= 1'b0;
                        bad_count  <= '0;
                        cpu_hold   <= 1'b1;
                        busy       <= 1'b1;
                        if (num_words != '0) begin
                            state      <= ST_RECV;
                            byte_ready <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_RECV: begin
                    if (wordValid) begin
                        state      <= ST_WRITE;
                        byte_ready <= 1'b0;
                        mem_we     <= 1'b1;
                        mem_addr   <= wordCnt[ADDR_WIDTH-1:0];
                        mem_wdata  <= word;
                    end
                end
                ST_WRITE: begin
                    mem_we  <= 1'b0;
                    wordCnt <= wordCnt + 1'b1;
                    // Unsupported words are still written; they are only counted.
                    if (!isSupportedOp(mem_wdata[31:26])) begin
                        bad_op    <= 1'b1;
                        bad_count <= bad_count + 1'b1;
                    end
                    if (wordCnt == numLatched - 1'b1) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state      <= ST_RECV;
                        byte_ready <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done     <= 1'b0;
                    cpu_hold <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
